// File: rtl/uart_rx.sv
// 8N1 UART receiver with input synchronizer, mid-bit sampling FSM and a one-entry valid/ready holding register.
// Define UART_RX_MAJORITY_EN to take each start/data/stop sample as a 2-of-3 vote around the nominal point.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample one clock after mid-bit; delaying the start
  // decision by one clock shifts every later sample by the same amount.
  localparam logic [TW-1:0] START_SAMPLE = TW'(CLKS_PER_BIT / 2);
`else
  localparam logic [TW-1:0] START_SAMPLE = TW'(CLKS_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rxData_q, rxData_d;
  logic            rxValid_q, rxValid_d;
  logic            frameErr_q, frameErr_d;
  logic            overrun_q, overrun_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            rx_s;
  logic            sampleBit;

  // Synchronizer presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '1;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sampleBit = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sampleBit = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q == BIT_LAST) ? '0 : timer_q + 1'b1;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    rxData_d   = rxData_q;
    rxValid_d  = rxValid_q & ~rx_ready;
    frameErr_d = 1'b0;
    overrun_d  = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (timer_q == START_SAMPLE) begin
          timer_d  = '0;
          bitIdx_d = '0;
          state_d  = sampleBit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          shift_d[bitIdx_q] = sampleBit;
          bitIdx_d          = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          if (sampleBit) begin
            state_d = IDLE;
            // A byte only replaces the held one if the old one leaves this clock.
            if (!rxValid_q || rx_ready) begin
              rxData_d  = shift_q;
              rxValid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frameErr_d = 1'b1;
            state_d    = BREAK;
          end
        end
      end
      BREAK: begin
        timer_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data   = rxData_q;
  assign rx_valid  = rxValid_q;
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: expected bytes are queued as frames are driven
// and compared when the receiver hands them over; flag pulses are counted alongside.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int SYN = 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errorCount = 0;
  int checkCount = 0;
  int validCycles = 0;
  int frameErrCount = 0;
  int overrunCount = 0;
  logic [7:0] expQ[$];

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; glitch inverts rx for one clock at the middle of each data bit.
  task automatic applyStimulus(input logic [7:0] data, input bit glitch, input bit stopVal, input int stopBits);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (glitch) begin
        tick(CPB / 2);
        rx = ~data[i];
        tick(1);
        rx = data[i];
        tick(CPB / 2 - 1);
      end else begin
        tick(CPB);
      end
    end
    rx = stopVal;
    tick(CPB * stopBits);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 40 * CPB && expQ.size() != 0; i++) begin
      tick(1);
    end
    checkOutput(tag, expQ.size(), 0);
  endtask

  // Scoreboard side: every handshake must match the oldest queued byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) validCycles++;
      if (frame_err) frameErrCount++;
      if (overrun) overrunCount++;
      if (rx_valid && rx_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedByte", {24'h0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("rxData", {24'h0, rx_data}, {24'h0, expQ.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vBase;
    int fBase;
    int oBase;
    logic [7:0] glitchExp;

    rx       = 1'b1;
    rx_ready = 1'b1;
    rst_n    = 1'b0;
    tick(3);
    checkOutput("resetData", {24'h0, rx_data}, 0);
    checkOutput("resetValid", {31'h0, rx_valid}, 0);
    checkOutput("resetFrameErr", {31'h0, frame_err}, 0);
    checkOutput("resetOverrun", {31'h0, overrun}, 0);
    checkOutput("resetBusy", {31'h0, busy}, 0);
    rst_n = 1'b1;
    tick(4);

    $display("[TB] single frame 0xA5");
    vBase = validCycles; fBase = frameErrCount; oBase = overrunCount;
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b0, 1'b1, 1);
    waitDrain("drainA5");
    tick(4);
    checkOutput("validOneClk", validCycles - vBase, 1);
    checkOutput("a5FrameErr", frameErrCount - fBase, 0);
    checkOutput("a5Overrun", overrunCount - oBase, 0);
    checkOutput("a5Idle", {31'h0, busy}, 0);

    $display("[TB] back-to-back frames with consumer stalled");
    rx_ready = 1'b0;
    oBase = overrunCount;
    expQ.push_back(8'h00);
    applyStimulus(8'h00, 1'b0, 1'b1, 1);
    applyStimulus(8'hFF, 1'b0, 1'b1, 1);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1);
    tick(2);
    checkOutput("heldValid", {31'h0, rx_valid}, 1);
    checkOutput("heldData", {24'h0, rx_data}, 0);
    checkOutput("overrunTwice", overrunCount - oBase, 2);
    rx_ready = 1'b1;
    waitDrain("drainHeld");
    tick(2);
    checkOutput("validCleared", {31'h0, rx_valid}, 0);

    $display("[TB] stop bit held low");
    fBase = frameErrCount; vBase = validCycles;
    applyStimulus(8'h55, 1'b0, 1'b0, 20);
    checkOutput("breakBusy1", {31'h0, busy}, 1);
    tick(20 * CPB);
    checkOutput("breakBusy2", {31'h0, busy}, 1);
    rx = 1'b1;
    tick(CPB);
    checkOutput("breakIdle", {31'h0, busy}, 0);
    checkOutput("oneFrameErr", frameErrCount - fBase, 1);
    checkOutput("breakNoValid", validCycles - vBase, 0);
    expQ.push_back(8'h12);
    applyStimulus(8'h12, 1'b0, 1'b1, 1);
    waitDrain("drain12");

    $display("[TB] short start glitch");
    fBase = frameErrCount; vBase = validCycles;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * CPB);
    checkOutput("glitchIdle", {31'h0, busy}, 0);
    checkOutput("glitchNoErr", frameErrCount - fBase, 0);
    checkOutput("glitchNoValid", validCycles - vBase, 0);

    $display("[TB] reset mid-frame");
    rx_ready = 1'b0;
    applyStimulus(8'h99, 1'b0, 1'b1, 1);
    tick(2);
    checkOutput("preResetValid", {31'h0, rx_valid}, 1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      tick(CPB);
    end
    rx = 1'b0;
    tick(CPB / 2);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncValid", {31'h0, rx_valid}, 0);
    checkOutput("asyncData", {24'h0, rx_data}, 0);
    checkOutput("asyncBusy", {31'h0, busy}, 0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    rx_ready = 1'b1;
    expQ.push_back(8'h7E);
    applyStimulus(8'h7E, 1'b0, 1'b1, 1);
    waitDrain("drain7E");

    $display("[TB] mid-bit glitches on 0xC3");
`ifdef UART_RX_MAJORITY_EN
    glitchExp = 8'hC3;
`else
    glitchExp = 8'h3C;
`endif
    expQ.push_back(glitchExp);
    applyStimulus(8'hC3, 1'b1, 1'b1, 1);
    waitDrain("drainC3");

    tick(CPB);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the 8N1 line driven by the UART transmitter: one start bit (0), 8 data bits LSB first, one stop bit (1), line idles high.
- Samples the asynchronous rx line with a counter-based bit timer in the system clock domain.
- Recovers bytes and presents them on a one-entry valid/ready output register to the consuming logic (command parser / loopback checker).
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 16: system clocks per serial bit. Must be at least 4.
- SYNC_STAGES, 2: flip-flops in the rx input synchronizer. Must be at least 2.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- rx_data  output  8  received byte. Valid while rx_valid=1.
- rx_valid  output  1  byte available in the holding register.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun  output  1  one-clk pulse: a byte completed while the holding register was still full.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert use):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops preset to 1. FSM goes to IDLE. Bit counter and timer cleared.
- Input path: rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s. Synchronizer latency is SYNC_STAGES clocks.
- Timer: counts 0..CLKS_PER_BIT-1, then wraps to 0. It restarts at 0 on every state entry.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rx_s=0, go to START.
  - START: when timer reaches CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - Sample 0: go to DATA, timer 0, bit index 0. This aligns later samples to mid-bit.
    - Sample 1: false start (glitch), return to IDLE. No flags raised.
  - DATA: each time the timer reaches CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first) and increment the index. After index 7 is sampled, go to STOP.
  - STOP: when the timer reaches CLKS_PER_BIT-1, sample rx_s.
    - Sample 1: the byte completes; go to IDLE.
    - Sample 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. A held-low line produces exactly one frame_err, not repeated errors.
- Byte completion (the clock the stop bit samples 1):
  - If rx_valid=0, or rx_valid & rx_ready in that same clock: load rx_data and set rx_valid=1 on the next edge.
  - Otherwise: pulse overrun, drop the new byte, keep the old rx_data and rx_valid.
- Handshake:
  - rx_valid clears on the clock after rx_valid & rx_ready, unless a new byte loads in the same clock.
  - rx_data is stable while rx_valid=1 and rx_ready=0.
- Latency: rx_valid rises SYNC_STAGES + about 9.5 × CLKS_PER_BIT + 1 clocks after the rx start edge.
- Back-to-back frames: a start bit that immediately follows the stop sample is detected from IDLE. No idle gap is required.
- Reset mid-frame: partial byte discarded, FSM returns to IDLE, holding register cleared.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each START, DATA and STOP sample is the 2-of-3 majority of rx_s at timer values T-1, T and T+1, where T is the nominal sample point.
  - Requires CLKS_PER_BIT ≥ 4.
  - Samples are taken one clock later than the nominal point; all other timing is unchanged.
- Undefined: single sample at T. No majority logic is present.

Test Plan:
- CLKS_PER_BIT=16: drive frame 0xA5 (bits 0,1,0,1,0,0,1,0,1,1) with rx_ready=1 -> rx_valid for 1 clk, rx_data=0xA5, no flags.
- Three back-to-back frames 0x00, 0xFF, 0x3C with rx_ready=0 throughout -> rx_data stays 0x00, rx_valid stays 1, overrun pulses twice. Then rx_ready=1 -> rx_valid drops after one handshake.
- Frame 0x55 with the stop bit held low for 40 bit times -> exactly one frame_err pulse, rx_valid stays 0, busy=1 until rx returns high. Then a 0x12 frame is received correctly.
- rx low pulse of 3 clks (shorter than CLKS_PER_BIT/2) -> returns to IDLE, no rx_valid, no frame_err.
- Assert rst_n=0 during data bit 4 of a 0x81 frame -> all outputs 0 asynchronously. After release, the next full 0x7E frame yields rx_data=0x7E.
- UART_RX_MAJORITY_EN defined: 1-clk glitch inverting rx at the mid-point of each data bit of 0xC3 -> rx_data=0xC3. Same stimulus with the macro undefined -> rx_data=0x3C.
